// File: rtl/axi4lite_read.sv
// AXI4-Lite read-channel responder: one outstanding AR/R transaction handed to user logic as a held request.
// Optional REQ-state timeout with SLVERR response is compiled in by defining AXI4LITE_READ_TIMEOUT_EN.
module axi4lite_read #(
    parameter int ADDR_WIDTH     = 40,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] axi_araddr,
    input  logic [2:0]            axi_arprot,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    output logic [DATA_WIDTH-1:0] axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [2:0]            rd_prot,
    input  logic                  rd_ack,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("axi4lite_read: TIMEOUT_CYCLES must be at least 1");
    end

    state_t                  state_r;
    state_t                  state_next_s;

    logic                    arready_r;
    logic                    rvalid_r;
    logic                    rd_req_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic [1:0]              rresp_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [2:0]              prot_r;

    logic                    arready_next_s;
    logic                    rvalid_next_s;
    logic                    rd_req_next_s;
    logic [DATA_WIDTH-1:0]   rdata_next_s;
    logic [1:0]              rresp_next_s;
    logic [ADDR_WIDTH-1:0]   addr_next_s;
    logic [2:0]              prot_next_s;

    logic                    accept_s;
    logic                    ack_s;
    logic                    r_hs_s;
    logic                    timeout_s;

    // arready_r gates acceptance so the first IDLE cycle after reset cannot take an address
    assign accept_s = (state_r == ST_IDLE) && arready_r && axi_arvalid;
    assign ack_s    = (state_r == ST_REQ) && rd_ack;
    assign r_hs_s   = (state_r == ST_RESP) && axi_rready;

`ifdef AXI4LITE_READ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_r;

    // Counts unacknowledged REQ cycles; held at zero outside REQ so every entry starts fresh
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r != ST_REQ) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (!rd_ack) begin
            wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // The edge ending the TIMEOUT_CYCLES-th REQ cycle gives up; a same-cycle ack wins
    assign timeout_s = (state_r == ST_REQ) && !rd_ack && (wait_cnt_r == CNT_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_s || timeout_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_RESP: begin
                if (r_hs_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        arready_next_s = arready_r;
        rvalid_next_s  = rvalid_r;
        rd_req_next_s  = rd_req_r;
        rdata_next_s   = rdata_r;
        rresp_next_s   = rresp_r;
        addr_next_s    = addr_r;
        prot_next_s    = prot_r;
        case (state_r)
            ST_IDLE: begin
                rvalid_next_s = 1'b0;
                if (accept_s) begin
                    arready_next_s = 1'b0;
                    rd_req_next_s  = 1'b1;
                    addr_next_s    = axi_araddr;
                    prot_next_s    = axi_arprot;
                end else begin
                    arready_next_s = 1'b1;
                    rd_req_next_s  = 1'b0;
                end
            end
            ST_REQ: begin
                arready_next_s = 1'b0;
                if (ack_s) begin
                    rd_req_next_s = 1'b0;
                    rvalid_next_s = 1'b1;
                    rdata_next_s  = rd_data;
                    rresp_next_s  = rd_err ? RESP_SLVERR : RESP_OKAY;
                end else if (timeout_s) begin
                    rd_req_next_s = 1'b0;
                    rvalid_next_s = 1'b1;
                    rdata_next_s  = {DATA_WIDTH{1'b0}};
                    rresp_next_s  = RESP_SLVERR;
                end else begin
                    rd_req_next_s = 1'b1;
                    rvalid_next_s = 1'b0;
                end
            end
            ST_RESP: begin
                rd_req_next_s = 1'b0;
                // rdata/rresp intentionally keep their value after the handshake
                if (r_hs_s) begin
                    rvalid_next_s  = 1'b0;
                    arready_next_s = 1'b1;
                end else begin
                    rvalid_next_s  = 1'b1;
                    arready_next_s = 1'b0;
                end
            end
            default: begin
                arready_next_s = 1'b0;
                rvalid_next_s  = 1'b0;
                rd_req_next_s  = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rd_req_r  <= 1'b0;
            rdata_r   <= {DATA_WIDTH{1'b0}};
            rresp_r   <= 2'b00;
            addr_r    <= {ADDR_WIDTH{1'b0}};
            prot_r    <= 3'b000;
        end else begin
            arready_r <= arready_next_s;
            rvalid_r  <= rvalid_next_s;
            rd_req_r  <= rd_req_next_s;
            rdata_r   <= rdata_next_s;
            rresp_r   <= rresp_next_s;
            addr_r    <= addr_next_s;
            prot_r    <= prot_next_s;
        end
    end

    assign axi_arready = arready_r;
    assign axi_rvalid  = rvalid_r;
    assign axi_rdata   = rdata_r;
    assign axi_rresp   = rresp_r;
    assign rd_req      = rd_req_r;
    assign rd_addr     = addr_r;
    assign rd_prot     = prot_r;

endmodule
